// File: rtl/spi_master.sv
// Memory-mapped SPI master: mode 0, MSB first, one byte per START, software-driven chip select.
// Registers: CTRL 0x08, START 0x09, STATUS 0x0a, TX_DATA 0x0b, RX_DATA 0x0c.
module spi_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        we,
   input  logic [7:0]  address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        spi_ss,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam logic [7:0] AddrCtrl   = 8'h08;
   localparam logic [7:0] AddrStart  = 8'h09;
   localparam logic [7:0] AddrStatus = 8'h0a;
   localparam logic [7:0] AddrTx     = 8'h0b;
   localparam logic [7:0] AddrRx     = 8'h0c;
   localparam logic [7:0] DivLast    = 8'(CLK_DIV - 1);

   typedef enum logic [1:0] {StIdle, StSckLo, StSckHi} state_e;

   state_e      state_q, state_d;
   logic [7:0]  div_q, div_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  tx_q, tx_d;
   logic [7:0]  rx_q, rx_d;
   logic [2:0]  bit_q, bit_d;
   logic        busy_q, busy_d;
   logic        sck_q, sck_d;
   logic        sample_q, sample_d;
   logic        ctrl_q, ctrl_d;
   logic        ready_q;
   logic [31:0] rdata_q, rdata_d;
   logic        wr;
   logic        unused_wdata;

   assign wr           = cs & we;
   assign unused_wdata = ^write_data[31:8];

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      bit_d    = bit_q;
      busy_d   = busy_q;
      sck_d    = sck_q;
      sample_d = sample_q;
      ctrl_d   = ctrl_q;

      // CTRL and TX_DATA are frozen for the whole byte so ss and shift data stay stable.
      if (wr && !busy_q) begin
         if (address == AddrCtrl) ctrl_d = write_data[0];
         if (address == AddrTx)   tx_d   = write_data[7:0];
      end

      unique case (state_q)
         StIdle: begin
            if (wr && address == AddrStart) begin
               shift_d = tx_q;
               bit_d   = 3'd0;
               div_d   = 8'd0;
               busy_d  = 1'b1;
               state_d = StSckLo;
            end
         end
         StSckLo: begin
            if (div_q == DivLast) begin
               div_d    = 8'd0;
               sck_d    = 1'b1;
               sample_d = spi_miso;
               state_d  = StSckHi;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         StSckHi: begin
            if (div_q == DivLast) begin
               div_d   = 8'd0;
               sck_d   = 1'b0;
               shift_d = {shift_q[6:0], sample_q};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  rx_d    = {shift_q[6:0], sample_q};
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end else begin
                  state_d = StSckLo;
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rdata_d = '0;
      if (cs && !we) begin
         case (address)
            AddrCtrl:   rdata_d[0]   = ctrl_q;
            AddrStatus: rdata_d[1:0] = {busy_q, ~busy_q};
            AddrTx:     rdata_d[7:0] = tx_q;
            AddrRx:     rdata_d[7:0] = rx_q;
            default:    rdata_d      = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         div_q    <= '0;
         shift_q  <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         bit_q    <= '0;
         busy_q   <= 1'b0;
         sck_q    <= 1'b0;
         sample_q <= 1'b0;
         ctrl_q   <= 1'b0;
         ready_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         bit_q    <= bit_d;
         busy_q   <= busy_d;
         sck_q    <= sck_d;
         sample_q <= sample_d;
         ctrl_q   <= ctrl_d;
         ready_q  <= cs;
         rdata_q  <= rdata_d;
      end
   end

   assign spi_ss    = ~ctrl_q;
   assign spi_sck   = sck_q;
   assign spi_mosi  = shift_q[7];
   assign read_data = rdata_q;
   assign ready     = ready_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomized scoreboard bench for spi_master: bus reads checked by a ready-driven monitor,
// SPI pin activity checked against edge times and bit values derived from the transfer rules.
module tb_spi_master;

   localparam int unsigned CD = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cs = 1'b0;
   logic        we = 1'b0;
   logic [7:0]  address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   logic        spi_ss, spi_sck, spi_mosi, spi_miso;

   logic        loop_en = 1'b0;
   logic        slave_bit = 1'b0;
   logic [7:0]  slave_byte = '0;
   int          slave_idx = 0;
   logic [7:0]  last_rx = '0;

   assign spi_miso = loop_en ? spi_mosi : slave_bit;

   spi_master #(.CLK_DIV(CD)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cs         (cs),
      .we         (we),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .spi_ss     (spi_ss),
      .spi_sck    (spi_sck),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   logic [31:0] exp_val[$];
   bit          exp_rd[$];
   string       exp_name[$];
   int          rise_t[$];
   int          fall_t[$];
   logic        mosi_at_rise[$];
   logic        sck_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops one expected entry per ready cycle and records SCK edges.
   always @(negedge clk) begin
      if (spi_sck && !sck_prev) begin
         rise_t.push_back(cyc);
         mosi_at_rise.push_back(spi_mosi);
      end
      if (!spi_sck && sck_prev) fall_t.push_back(cyc);
      sck_prev = spi_sck;
      if (ready) begin
         if (exp_rd.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious ready: got 1 expected 0 (cycle %0d)", cyc);
         end else begin
            bit          rd;
            logic [31:0] v;
            string       n;
            rd = exp_rd.pop_front();
            v  = exp_val.pop_front();
            n  = exp_name.pop_front();
            if (rd) chk(n, read_data, v);
         end
      end
   end

   // Slave shifts its next bit out after each SCK falling edge.
   always @(negedge spi_sck) begin
      slave_idx++;
      if (slave_idx < 8) slave_bit = slave_byte[7 - slave_idx];
   end

   task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic [31:0] e, input string n);
      exp_rd.push_back(!w);
      exp_val.push_back(e);
      exp_name.push_back(n);
      cs = 1'b1;
      we = w;
      address = a;
      write_data = d;
      @(negedge clk);
      chk({n, " ready"}, 32'(ready), 32'd1);
      cs = 1'b0;
      we = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      if (cyc > target) chk("schedule", 32'(cyc), 32'(target));
      while (cyc < target) @(negedge clk);
   endtask

   task automatic transfer(input logic [7:0] tx, input logic [7:0] slv, input logic lp,
                           input logic inject);
      int         t0;
      logic [7:0] exp_rx;
      exp_rx     = lp ? tx : slv;
      loop_en    = lp;
      slave_byte = slv;
      slave_idx  = 0;
      slave_bit  = slv[7];
      bus(1'b1, 8'h0b, 32'(tx), 32'd0, "wr tx");
      bus(1'b1, 8'h08, 32'd1, 32'd0, "wr ctrl");
      chk("ss asserted", 32'(spi_ss), 32'd0);
      rise_t.delete();
      fall_t.delete();
      mosi_at_rise.delete();
      bus(1'b1, 8'h09, 32'd0, 32'd0, "start");
      t0 = cyc;
      bus(1'b0, 8'h0a, 32'd0, 32'h2, "status first busy");
      if (inject) begin
         wait_cyc(t0 + 9);
         bus(1'b1, 8'h09, 32'd0, 32'd0, "restart");
         bus(1'b1, 8'h0b, 32'hff, 32'd0, "wr tx busy");
      end
      wait_cyc(t0 + 16 * CD - 1);
      bus(1'b0, 8'h0a, 32'd0, 32'h2, "status last busy");
      bus(1'b0, 8'h0a, 32'd0, 32'h1, "status idle");
      bus(1'b0, 8'h0c, 32'd0, 32'(exp_rx), "rx data");
      if (inject) bus(1'b0, 8'h0b, 32'd0, 32'(tx), "tx kept");
      @(negedge clk);
      chk("ss held", 32'(spi_ss), 32'd0);
      chk("sck rises", 32'(rise_t.size()), 32'd8);
      chk("sck falls", 32'(fall_t.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < rise_t.size()) begin
            chk("rise time", 32'(rise_t[i]), 32'(t0 + CD + 2 * CD * i));
            chk("mosi bit", 32'(mosi_at_rise[i]), 32'(tx[7 - i]));
         end
         if (i < fall_t.size()) chk("fall time", 32'(fall_t[i]), 32'(t0 + 2 * CD * (i + 1)));
      end
      last_rx = exp_rx;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("reset ss", 32'(spi_ss), 32'd1);
      chk("reset sck", 32'(spi_sck), 32'd0);
      chk("reset mosi", 32'(spi_mosi), 32'd0);
      bus(1'b0, 8'h0a, 32'd0, 32'h1, "reset status");
      bus(1'b0, 8'h0c, 32'd0, 32'h0, "reset rx");
      bus(1'b0, 8'h08, 32'd0, 32'h0, "reset ctrl");
      bus(1'b0, 8'h0b, 32'd0, 32'h0, "reset tx");

      transfer(8'ha5, 8'h00, 1'b1, 1'b0);
      transfer(8'h00, 8'h3c, 1'b0, 1'b0);
      transfer(8'h5a, 8'hc3, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         transfer(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      end

      bus(1'b0, 8'h00, 32'd0, 32'h0, "unmapped read");
      bus(1'b1, 8'h0c, 32'h55, 32'd0, "wr rx");
      bus(1'b1, 8'h00, 32'hffff_ffff, 32'd0, "wr unmapped");
      bus(1'b0, 8'h0c, 32'd0, 32'(last_rx), "rx unchanged");
      bus(1'b0, 8'h08, 32'd0, 32'h1, "ctrl unchanged");

      // Reset in the middle of a byte.
      bus(1'b1, 8'h0b, 32'($urandom_range(0, 255)), 32'd0, "wr tx");
      bus(1'b1, 8'h09, 32'd0, 32'd0, "start");
      t0 = cyc;
      wait_cyc(t0 + 19);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midreset ss", 32'(spi_ss), 32'd1);
      chk("midreset sck", 32'(spi_sck), 32'd0);
      @(negedge clk);
      rise_t.delete();
      fall_t.delete();
      reset_n = 1'b1;
      bus(1'b0, 8'h0a, 32'd0, 32'h1, "midreset status");
      bus(1'b0, 8'h0c, 32'd0, 32'h0, "midreset rx");
      bus(1'b0, 8'h08, 32'd0, 32'h0, "midreset ctrl");
      repeat (20 * CD) @(negedge clk);
      chk("no sck after reset", 32'(rise_t.size() + fall_t.size()), 32'd0);
      chk("queue drained", 32'(exp_rd.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
